bus_split_arbiter: RTL and testbench

//  Two-master bus arbiter with split-transaction support for the serial bus (3 slaves).

---
 rtl/bus_split_arbiter_if.sv | 25 ++
 rtl/bus_split_arbiter.sv | 157 +++++++++++++++
 tb/tb_bus_split_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_split_arbiter_if.sv
// Bus-side signal bundle for bus_split_arbiter: master requests and slave
// responses in, one-hot grant and status out.
`timescale 1ns/1ps

interface bus_split_arbiter_if;
  logic [1:0] b_req;
  logic       b_util;
  logic       b_done;
  logic       b_split;
  logic       b_spl_resume;
  logic [1:0] b_grant;
  logic       b_busy;
  logic [1:0] split_pend;
  logic       timeout_err;

  modport master (
    output b_req, b_util, b_done, b_split, b_spl_resume,
    input  b_grant, b_busy, split_pend, timeout_err
  );

  modport slave (
    input  b_req, b_util, b_done, b_split, b_spl_resume,
    output b_grant, b_busy, split_pend, timeout_err
  );
endinterface

// File: rtl/bus_split_arbiter.sv
// Two-master serial-bus arbiter with split-transaction parking and ordered resume.
// Define ARB_ROUND_ROBIN_EN for round-robin fresh arbitration; default is fixed priority (M0 first).
`timescale 1ns/1ps

module bus_split_arbiter #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  bus_split_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GNT, BUSY} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         rc_q, rc_d;
  logic               oldest_q, oldest_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [1:0]         elig_c;
  logic               win_c;

  assign elig_c = bus.b_req & ~pend_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Last-granted master loses a tie; pointer resets to M1 so M0 wins first.
  always_comb begin
    win_c = 1'b0;
    if (elig_c == 2'b11) win_c = ~last_q;
    else                 win_c = elig_c[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`else
  always_comb begin
    win_c = 1'b0;
    if (!elig_c[0]) win_c = elig_c[1];
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    rc_d     = rc_q;
    oldest_d = oldest_q;
    err_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (rc_q != 2'd0) begin
          // Resume service outranks fresh requests; the other master becomes oldest.
          grant_d          = oldest_q ? 2'b10 : 2'b01;
          owner_d          = oldest_q;
          pend_d[oldest_q] = 1'b0;
          rc_d             = rc_q - 2'd1;
          oldest_d         = ~oldest_q;
          cnt_d            = '0;
          state_d          = GNT;
`ifdef ARB_ROUND_ROBIN_EN
          last_d           = oldest_q;
`endif
        end else if (elig_c != 2'b00) begin
          grant_d = win_c ? 2'b10 : 2'b01;
          owner_d = win_c;
          cnt_d   = '0;
          state_d = GNT;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = win_c;
`endif
        end
      end
      GNT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.b_util) begin
          cnt_d   = '0;
          state_d = BUSY;
        end else if (!bus.b_req[owner_q]) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          grant_d = 2'b00;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.b_split) begin
          if (pend_q == 2'b00) oldest_d = owner_q;
          pend_d[owner_q] = 1'b1;
          grant_d         = 2'b00;
          state_d         = IDLE;
        end else if (bus.b_done || !bus.b_util) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase

    // Resume counts against flags already updated by this cycle's split/serve.
    if (bus.b_spl_resume && (pend_d != 2'b00)) begin
      if (rc_d < (2'({1'b0, pend_d[0]}) + 2'({1'b0, pend_d[1]}))) rc_d = rc_d + 2'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= 2'b00;
      rc_q     <= 2'd0;
      oldest_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rc_q     <= rc_d;
      oldest_q <= oldest_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.b_grant     = grant_q;
  assign bus.b_busy      = busy_q;
  assign bus.split_pend  = pend_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Directed self-checking bench for bus_split_arbiter (TIMEOUT=8); expectations
// follow ARB_ROUND_ROBIN_EN when the design is built with it.
`timescale 1ns/1ps

module tb_bus_split_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  bus_split_arbiter_if bus_if ();

  bus_split_arbiter #(.TIMEOUT(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.b_req        = 2'b00;
    bus_if.b_util       = 1'b0;
    bus_if.b_done       = 1'b0;
    bus_if.b_split      = 1'b0;
    bus_if.b_spl_resume = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Owner is in GNT on entry; leaves the arbiter in IDLE with grant dropped.
  task automatic complete_xfer();
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_done = 1'b1;
    tick();
    bus_if.b_done = 1'b0;
    bus_if.b_util = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b expected 00", bus_if.b_grant); end
    tests_run++;
    if (bus_if.b_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus_if.b_busy); end
    tests_run++;
    if (bus_if.split_pend !== 2'b00) begin tests_failed++; $display("FAIL reset_pend: got %b expected 00", bus_if.split_pend); end
    tests_run++;
    if (bus_if.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bus_if.timeout_err); end
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL reset_idle_grant: got %b expected 00", bus_if.b_grant); end
  endtask

  task automatic test_basic();
    bus_if.b_req = 2'b01;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b01) begin tests_failed++; $display("FAIL basic_grant: got %b expected 01", bus_if.b_grant); end
    tests_run++;
    if (bus_if.b_busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %b expected 1", bus_if.b_busy); end
    complete_xfer();
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL basic_release: got %b expected 00", bus_if.b_grant); end
    tests_run++;
    if (bus_if.b_busy !== 1'b0) begin tests_failed++; $display("FAIL basic_idle_busy: got %b expected 0", bus_if.b_busy); end
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b01) begin tests_failed++; $display("FAIL basic_turnaround: got %b expected 01", bus_if.b_grant); end
    complete_xfer();
    bus_if.b_req = 2'b00;
    tick();
  endtask

  task automatic test_priority();
    logic [1:0] exp_seq [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    apply_reset();
    bus_if.b_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (bus_if.b_grant !== exp_seq[i]) begin tests_failed++; $display("FAIL prio_grant%0d: got %b expected %b", i, bus_if.b_grant, exp_seq[i]); end
      complete_xfer();
      tests_run++;
      if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL prio_gap%0d: got %b expected 00", i, bus_if.b_grant); end
    end
    bus_if.b_req = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    bus_if.b_req = 2'b01;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b01) begin tests_failed++; $display("FAIL to_grant: got %b expected 01", bus_if.b_grant); end
    for (int k = 1; k < 8; k++) begin
      tick();
      tests_run++;
      if (bus_if.b_grant !== 2'b01 || bus_if.timeout_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL to_hold%0d: got grant %b err %b expected 01 0", k, bus_if.b_grant, bus_if.timeout_err);
      end
    end
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL to_drop: got %b expected 00", bus_if.b_grant); end
    tests_run++;
    if (bus_if.timeout_err !== 1'b1) begin tests_failed++; $display("FAIL to_err_pulse: got %b expected 1", bus_if.timeout_err); end
    bus_if.b_req = 2'b00;
    tick();
    tests_run++;
    if (bus_if.timeout_err !== 1'b0) begin tests_failed++; $display("FAIL to_err_width: got %b expected 0", bus_if.timeout_err); end
  endtask

  task automatic test_req_drop();
    bus_if.b_req = 2'b10;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b10) begin tests_failed++; $display("FAIL drop_grant: got %b expected 10", bus_if.b_grant); end
    bus_if.b_req = 2'b00;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00 || bus_if.timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_release: got grant %b err %b expected 00 0", bus_if.b_grant, bus_if.timeout_err);
    end
  endtask

  task automatic test_split();
    bus_if.b_req = 2'b01;
    tick();
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_split = 1'b1;
    bus_if.b_done  = 1'b1;
    tick();
    bus_if.b_split = 1'b0;
    bus_if.b_done  = 1'b0;
    bus_if.b_util  = 1'b0;
    tests_run++;
    if (bus_if.split_pend !== 2'b01) begin tests_failed++; $display("FAIL split_pend: got %b expected 01", bus_if.split_pend); end
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL split_grant: got %b expected 00", bus_if.b_grant); end
    bus_if.b_req = 2'b11;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b10) begin tests_failed++; $display("FAIL split_mask: got %b expected 10", bus_if.b_grant); end
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_spl_resume = 1'b1;
    tick();
    bus_if.b_spl_resume = 1'b0;
    bus_if.b_done = 1'b1;
    tick();
    bus_if.b_done = 1'b0;
    bus_if.b_util = 1'b0;
    tests_run++;
    if (bus_if.b_grant !== 2'b00 || bus_if.split_pend !== 2'b01) begin
      tests_failed++;
      $display("FAIL split_m1_release: got grant %b pend %b expected 00 01", bus_if.b_grant, bus_if.split_pend);
    end
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b01 || bus_if.split_pend !== 2'b00) begin
      tests_failed++;
      $display("FAIL split_resume: got grant %b pend %b expected 01 00", bus_if.b_grant, bus_if.split_pend);
    end
    complete_xfer();
    bus_if.b_req = 2'b00;
    tick();
  endtask

  task automatic test_two_splits();
    bus_if.b_req = 2'b01;
    tick();
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_split = 1'b1;
    tick();
    bus_if.b_split = 1'b0;
    bus_if.b_util  = 1'b0;
    bus_if.b_req   = 2'b10;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b10) begin tests_failed++; $display("FAIL two_m1_grant: got %b expected 10", bus_if.b_grant); end
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_split = 1'b1;
    tick();
    bus_if.b_split = 1'b0;
    bus_if.b_util  = 1'b0;
    tests_run++;
    if (bus_if.split_pend !== 2'b11 || bus_if.b_grant !== 2'b00) begin
      tests_failed++;
      $display("FAIL two_parked: got pend %b grant %b expected 11 00", bus_if.split_pend, bus_if.b_grant);
    end
    bus_if.b_req        = 2'b11;
    bus_if.b_spl_resume = 1'b1;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL two_masked: got %b expected 00", bus_if.b_grant); end
    tick();
    bus_if.b_spl_resume = 1'b0;
    tests_run++;
    if (bus_if.b_grant !== 2'b01 || bus_if.split_pend !== 2'b10) begin
      tests_failed++;
      $display("FAIL two_first: got grant %b pend %b expected 01 10", bus_if.b_grant, bus_if.split_pend);
    end
    complete_xfer();
    tests_run++;
    if (bus_if.b_grant !== 2'b00) begin tests_failed++; $display("FAIL two_gap: got %b expected 00", bus_if.b_grant); end
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b10 || bus_if.split_pend !== 2'b00) begin
      tests_failed++;
      $display("FAIL two_second: got grant %b pend %b expected 10 00", bus_if.b_grant, bus_if.split_pend);
    end
    complete_xfer();
    bus_if.b_req = 2'b00;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00 || bus_if.split_pend !== 2'b00) begin
      tests_failed++;
      $display("FAIL two_end: got grant %b pend %b expected 00 00", bus_if.b_grant, bus_if.split_pend);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus_if.b_req = 2'b01;
    tick();
    bus_if.b_util = 1'b1;
    tick();
    bus_if.b_split = 1'b1;
    tick();
    bus_if.b_split = 1'b0;
    bus_if.b_util  = 1'b0;
    bus_if.b_req   = 2'b10;
    tick();
    bus_if.b_util = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.b_grant !== 2'b00 || bus_if.split_pend !== 2'b00 || bus_if.b_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got grant %b pend %b busy %b expected 00 00 0", bus_if.b_grant, bus_if.split_pend, bus_if.b_busy);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    bus_if.b_spl_resume = 1'b1;
    tick();
    bus_if.b_spl_resume = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b00 || bus_if.split_pend !== 2'b00) begin
      tests_failed++;
      $display("FAIL stale_resume: got grant %b pend %b expected 00 00", bus_if.b_grant, bus_if.split_pend);
    end
    bus_if.b_req = 2'b01;
    tick();
    tests_run++;
    if (bus_if.b_grant !== 2'b01) begin tests_failed++; $display("FAIL post_reset_grant: got %b expected 01", bus_if.b_grant); end
    bus_if.b_req = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_timeout();
    test_req_drop();
    test_split();
    test_two_splits();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
